// File: rtl/ft_pkg.sv
// ft_pkg: shared types and constants for the lockstep writeback aligner.
//   ft_state_e         - aligner FSM state (SYNC: both FIFOs empty or both
//                        non-empty; LAG: exactly one FIFO holds entries)
//   ft_ptr_width()     - FIFO pointer width; one extra bit beyond the index
//                        so that full (occupancy == DEPTH) never aliases empty
//   FT_DEFAULT_DEPTH   - default per-core FIFO depth
//   FT_DEFAULT_TIMEOUT - default cycles an unmatched head may wait
package ft_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    LAG  = 1'b1
  } ft_state_e;

  localparam int FT_DEFAULT_DEPTH   = 4;
  localparam int FT_DEFAULT_TIMEOUT = 8;

  function automatic int ft_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ft_wb_fifo.sv
// ft_wb_fifo: small synchronous FIFO holding {addr,data} writeback entries.
// Ports:
//   clk_i, rst_i - clock, asynchronous active-high reset
//   flush_i      - synchronous clear of both pointers
//   push_i       - write wdata_i; caller guarantees it is legal (not full,
//                  or popping in the same cycle)
//   pop_i        - advance the read pointer; caller guarantees non-empty
//   wdata_i      - entry to store
//   rdata_o      - current head entry (valid while empty_o is 0)
//   full_o       - occupancy equals DEPTH
//   empty_o      - occupancy is zero
//   occ_o        - occupancy, 0..DEPTH
module ft_wb_fifo
  import ft_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = FT_DEFAULT_DEPTH,
  localparam int PW   = ft_ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW-1:0]    occ_o
);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    w_occ;

  // Pointers carry one wrap bit, so the difference is the true occupancy.
  assign w_occ   = r_wr_ptr - r_rd_ptr;
  assign occ_o   = w_occ;
  assign full_o  = (w_occ == PW'(DEPTH));
  assign empty_o = (w_occ == '0);
  // The head is read straight from storage so the aligner can register it
  // in the same cycle the pop decision is made.
  assign rdata_o = r_mem[r_rd_ptr[PW-2:0]];

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      r_mem[r_wr_ptr[PW-2:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/ft_wb_aligner.sv
// ft_wb_aligner: lockstep skew absorber. Buffers core A and core B register
// writebacks in per-core FIFOs and presents them to the comparator in pairs,
// in order, in the same cycle. An unmatched head that waits TIMEOUT cycles
// is forced out one-sided together with a timeout pulse.
// Ports:
//   clk_i, rst_i                 - clock, asynchronous active-high reset
//   enable_i                     - accept writebacks; also gates the timeout count
//   flush_i                      - synchronous clear of all buffered state
//   we/addr/data_a_i, _b_i       - per-core writeback inputs
//   we/addr/data_a_o, _b_o       - aligned (registered) comparator inputs
//   timeout_o                    - one-cycle pulse on a forced one-sided output
//   overflow_o                   - sticky: a writeback was dropped
//   occ_a_o, occ_b_o             - FIFO occupancies
module ft_wb_aligner
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = FT_DEFAULT_DEPTH,
  parameter int TIMEOUT    = FT_DEFAULT_TIMEOUT,
  localparam int PW        = ft_ptr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  output logic                  we_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] addr_a_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic [DATA_WIDTH-1:0] data_a_o,
  output logic [DATA_WIDTH-1:0] data_b_o,
  output logic                  timeout_o,
  output logic                  overflow_o,
  output logic [PW-1:0]         occ_a_o,
  output logic [PW-1:0]         occ_b_o
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT) + 1;

  ft_state_e     r_state;
  ft_state_e     w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  logic [EW-1:0] w_head_a, w_head_b;
  logic          w_full_a, w_full_b;
  logic          w_empty_a, w_empty_b;
  logic [PW-1:0] w_occ_a, w_occ_b;
  logic [PW-1:0] w_occ_a_next, w_occ_b_next;

  logic w_push_a, w_push_b;
  logic w_push_ok_a, w_push_ok_b;
  logic w_pop_a, w_pop_b;
  logic w_drop_a, w_drop_b;
  logic w_pair, w_fire;

  // Requested pushes; flush discards anything presented in the same cycle.
  assign w_push_a = enable_i & we_a_i & ~flush_i;
  assign w_push_b = enable_i & we_b_i & ~flush_i;

  // Pairing and timeout are decided purely from registered FIFO state,
  // which gives the fixed two-cycle latency and no input-to-output path.
  assign w_pair = ~w_empty_a & ~w_empty_b & ~flush_i;
  assign w_fire = (r_state == LAG) & enable_i & ~flush_i &
                  (r_cnt == CW'(TIMEOUT - 1));

  // In LAG exactly one FIFO is non-empty, so a fire pops only that side.
  assign w_pop_a = w_pair | (w_fire & ~w_empty_a);
  assign w_pop_b = w_pair | (w_fire & ~w_empty_b);

  // A push into a full FIFO survives only if that FIFO pops this cycle.
  assign w_push_ok_a = w_push_a & (~w_full_a | w_pop_a);
  assign w_push_ok_b = w_push_b & (~w_full_b | w_pop_b);
  assign w_drop_a    = w_push_a & ~w_push_ok_a;
  assign w_drop_b    = w_push_b & ~w_push_ok_b;

  // Post-edge occupancies let the state register track the FIFOs exactly.
  assign w_occ_a_next = flush_i ? '0 : (w_occ_a + PW'(w_push_ok_a) - PW'(w_pop_a));
  assign w_occ_b_next = flush_i ? '0 : (w_occ_b + PW'(w_push_ok_b) - PW'(w_pop_b));

  always_comb begin
    w_state_next = ((w_occ_a_next != '0) ^ (w_occ_b_next != '0)) ? LAG : SYNC;
    w_cnt_next   = '0;
    // Count only while lagging continuously; entering LAG, returning to
    // SYNC or forcing a head out all restart the window from zero.
    if (r_state == LAG && w_state_next == LAG && !w_fire) begin
      w_cnt_next = enable_i ? (r_cnt + CW'(1)) : r_cnt;
    end
  end

  ft_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_push_ok_a),
    .pop_i   (w_pop_a),
    .wdata_i ({addr_a_i, data_a_i}),
    .rdata_o (w_head_a),
    .full_o  (w_full_a),
    .empty_o (w_empty_a),
    .occ_o   (w_occ_a)
  );

  ft_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (w_push_ok_b),
    .pop_i   (w_pop_b),
    .wdata_i ({addr_b_i, data_b_i}),
    .rdata_o (w_head_b),
    .full_o  (w_full_b),
    .empty_o (w_empty_b),
    .occ_o   (w_occ_b)
  );

  assign occ_a_o = w_occ_a;
  assign occ_b_o = w_occ_b;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= SYNC;
      r_cnt      <= '0;
      we_a_o     <= 1'b0;
      we_b_o     <= 1'b0;
      addr_a_o   <= '0;
      addr_b_o   <= '0;
      data_a_o   <= '0;
      data_b_o   <= '0;
      timeout_o  <= 1'b0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      r_state    <= SYNC;
      r_cnt      <= '0;
      we_a_o     <= 1'b0;
      we_b_o     <= 1'b0;
      timeout_o  <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      overflow_o <= overflow_o | w_drop_a | w_drop_b;
      if (w_pair) begin
        we_a_o    <= 1'b1;
        we_b_o    <= 1'b1;
        addr_a_o  <= w_head_a[EW-1 -: ADDR_WIDTH];
        data_a_o  <= w_head_a[DATA_WIDTH-1:0];
        addr_b_o  <= w_head_b[EW-1 -: ADDR_WIDTH];
        data_b_o  <= w_head_b[DATA_WIDTH-1:0];
        timeout_o <= 1'b0;
      end else if (w_fire) begin
        // One-sided output: the silent side is zeroed so the comparator
        // sees an unambiguous divergence.
        timeout_o <= 1'b1;
        if (!w_empty_a) begin
          we_a_o   <= 1'b1;
          we_b_o   <= 1'b0;
          addr_a_o <= w_head_a[EW-1 -: ADDR_WIDTH];
          data_a_o <= w_head_a[DATA_WIDTH-1:0];
          addr_b_o <= '0;
          data_b_o <= '0;
        end else begin
          we_a_o   <= 1'b0;
          we_b_o   <= 1'b1;
          addr_b_o <= w_head_b[EW-1 -: ADDR_WIDTH];
          data_b_o <= w_head_b[DATA_WIDTH-1:0];
          addr_a_o <= '0;
          data_a_o <= '0;
        end
      end else begin
        we_a_o    <= 1'b0;
        we_b_o    <= 1'b0;
        timeout_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ft_wb_aligner.md
Name: ft_wb_aligner

Overview:
- Lockstep skew absorber upstream of the fault-tolerance module.
- Buffers register-file writeback events (we/addr/data) from core A and core B in two small per-core FIFOs, then pairs them in order.
- Presents each pair to the comparator inputs in the same cycle, so a core running a few cycles ahead is not reported as an error.
- If one core writes and the other never matches within a bound, issues a one-sided write plus a timeout pulse so the comparator and controller see the divergence.

Parameters:
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, writeback data width.
- DEPTH, 4, entries per core FIFO; must be a power of 2 and at least 2.
- TIMEOUT, 8, cycles an unmatched head may wait before being forced out; must be at least 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- enable_i  in  1  accept new writebacks; when low, inputs are ignored
- flush_i  in  1  synchronous clear of all buffered state
- we_a_i  in  1  core A writeback valid
- addr_a_i  in  ADDR_WIDTH  core A destination register
- data_a_i  in  DATA_WIDTH  core A write data
- we_b_i, addr_b_i, data_b_i  in  1/ADDR_WIDTH/DATA_WIDTH  core B equivalents
- we_a_o, we_b_o  out  1  aligned write enables to the comparator
- addr_a_o, addr_b_o  out  ADDR_WIDTH  aligned addresses
- data_a_o, data_b_o  out  DATA_WIDTH  aligned data
- timeout_o  out  1  one-cycle pulse: forced one-sided output this cycle
- overflow_o  out  1  sticky: a writeback was dropped
- occ_a_o, occ_b_o  out  $clog2(DEPTH)+1  FIFO occupancies

Behaviour:
- Reset (async, rst_i=1): FIFOs empty, all outputs 0, timeout counter 0, FSM in SYNC.
- Push: a FIFO pushes when enable_i & we_x_i & ~flush_i.
  - Push into a full FIFO is allowed only if the same FIFO pops that cycle.
  - Otherwise the entry is dropped and overflow_o is set (sticky).
- Pair pop: when both FIFOs are non-empty (registered state), both heads pop.
  - Output registers load both heads; we_a_o = we_b_o = 1 for exactly one cycle.
  - Otherwise we_*_o = 0; addr/data outputs hold their last values.
- Latency: writebacks pushed in cycle t are visible on the outputs in cycle t+2. No combinational input-to-output path.
- Throughput: one pair per cycle, sustained.
- FSM and timeout:
  - SYNC: both FIFOs empty, or both non-empty.
  - LAG: exactly one FIFO non-empty. The counter increments every cycle in LAG, and freezes while enable_i = 0.
  - LAG -> SYNC when the other side becomes non-empty; the counter clears.
  - When the counter reaches TIMEOUT-1 in LAG: the next edge pops the lone head only and drives we_x_o = 1 on that side, we_other_o = 0, other side addr/data = 0.
  - That same output cycle pulses timeout_o = 1; the counter clears.
  - The FSM re-evaluates: it stays in LAG if entries remain, and the next head gets a fresh TIMEOUT window.
- Pair pop and timeout cannot coincide, since timeout requires one FIFO empty.
- flush_i: at the next edge, FIFOs empty, counter 0, overflow_o cleared, we_*_o and timeout_o 0, FSM to SYNC.
  - Writebacks presented during a flush cycle are discarded.
  - flush_i takes priority over push, pop and timeout.
- Reset mid-operation: all buffered entries are lost, with no output pulse.
- Occupancy wrap: pointers are $clog2(DEPTH)+1 bits, so full = DEPTH exactly with no aliasing.

Decomposition:
- ft_pkg holds:
  - the FSM state typedef (SYNC, LAG);
  - a localparam function for the pointer width;
  - the default TIMEOUT/DEPTH constants shared with the integration top.
- One sub-module, ft_wb_fifo: a parameterized sync FIFO of {addr,data} with push, pop, full, empty and occupancy. It is instantiated twice (A and B).
- Pairing, FSM, timeout counter and output registers live in ft_wb_aligner.

Test Plan:
- Same-cycle writes A,B (addr 3, data 0xDEADBEEF) at t -> outputs at t+2, we_a_o = we_b_o = 1, both addr 3, timeout_o = 0.
- A writes addr 1,2,3 in cycles 0-2; B writes the same in cycles 3-5 -> three pairs in order at cycles 5,6,7; occ_a_o peaks at 3; no timeout.
- A writes addr 7 / 0x55; B silent, TIMEOUT = 8 -> exactly one cycle with we_a_o = 1, we_b_o = 0, addr_a_o = 7, timeout_o = 1; then idle.
- A writes 5 back-to-back entries, B silent, DEPTH = 4 -> overflow_o rises and stays 1; occ_a_o = 4 until timeout drains begin; flush_i clears overflow_o.
- Assert flush_i with 2 entries in A and the counter mid-count -> next cycle occ_a_o = 0, no timeout pulse later.
- Assert rst_i asynchronously mid-stream (not on an edge) -> all outputs 0 immediately; no stale pair emitted after release.
